// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module : seg7_scan_display
// Brief  : N-digit time-multiplexed 7-segment driver with shift-in nibble buffer
//          and a blanking gap after every digit change.
// Rev    : 1.0
// ============================================================================
module seg7_scan_display #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_UNUSED   = 1'b1
) (
  input  logic                              FPGA_clk,
  input  logic                              FPGA_reset,
  input  logic [3:0]                        data_in,
  input  logic                              data_valid,
  input  logic                              clear,
  output logic [6:0]                        seg_out,
  output logic [NUM_DIGITS-1:0]             digit_en,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              buffer_full
);

  localparam int C_DIV   = CLK_HZ / (SCAN_HZ * NUM_DIGITS);
  localparam int C_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int C_CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int C_DIV_W = (C_DIV > 1) ? $clog2(C_DIV) : 1;
  localparam int C_GRD_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [6:0]            C_SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] C_DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  generate
    if (C_DIV < 1) begin : g_bad_div
      $error("seg7_scan_display: CLK_HZ/(SCAN_HZ*NUM_DIGITS) must be >= 1");
    end
    if (NUM_DIGITS < 1) begin : g_bad_digits
      $error("seg7_scan_display: NUM_DIGITS must be >= 1");
    end
  endgenerate

  logic [4*NUM_DIGITS-1:0] buf_q, buf_d, w_buf_shift;
  logic [C_CNT_W-1:0]      cnt_q, cnt_d;
  logic                    full_q, full_d;
  logic [C_DIV_W-1:0]      div_q, div_d;
  logic [C_IDX_W-1:0]      idx_q, idx_d;
  logic [C_GRD_W-1:0]      grd_q, grd_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    w_div_wrap;
  logic                    w_blank;
  logic [3:0]              w_nibble;
  logic [6:0]              w_font;
  logic [NUM_DIGITS-1:0]   w_onehot;

  // Newest nibble enters at digit 0; the oldest one falls off the top.
  generate
    if (NUM_DIGITS == 1) begin : g_shift_one
      assign w_buf_shift = data_in;
    end else begin : g_shift_n
      assign w_buf_shift = {buf_q[4*NUM_DIGITS-5:0], data_in};
    end
  endgenerate

  always_comb begin
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    w_div_wrap = (div_q == C_DIV_W'(C_DIV - 1));
    div_d      = w_div_wrap ? '0 : div_q + C_DIV_W'(1);
    idx_d      = idx_q;
    grd_d      = (grd_q != '0) ? grd_q - C_GRD_W'(1) : grd_q;

    if (clear) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (data_valid) begin
      buf_d = w_buf_shift;
      if (cnt_q != C_CNT_W'(NUM_DIGITS)) cnt_d = cnt_q + C_CNT_W'(1);
    end
    full_d = (cnt_d == C_CNT_W'(NUM_DIGITS));

    if (w_div_wrap) begin
      idx_d = (idx_q == C_IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + C_IDX_W'(1);
      grd_d = C_GRD_W'(BLANK_CYCLES);
    end

    w_nibble = buf_q[{idx_q, 2'b00} +: 4];
    case (w_nibble)
      4'h0: w_font = 7'h3F;
      4'h1: w_font = 7'h06;
      4'h2: w_font = 7'h5B;
      4'h3: w_font = 7'h4F;
      4'h4: w_font = 7'h66;
      4'h5: w_font = 7'h6D;
      4'h6: w_font = 7'h7D;
      4'h7: w_font = 7'h07;
      4'h8: w_font = 7'h7F;
      4'h9: w_font = 7'h6F;
      4'hA: w_font = 7'h77;
      4'hB: w_font = 7'h7C;
      4'hC: w_font = 7'h39;
      4'hD: w_font = 7'h5E;
      4'hE: w_font = 7'h79;
      default: w_font = 7'h71;
    endcase

    // Outputs follow the current scan state, so they lag idx/guard by one clock.
    w_blank  = (grd_q != '0) || (BLANK_UNUSED && (C_CNT_W'(idx_q) >= cnt_q));
    seg_d    = w_blank ? C_SEG_OFF : (SEG_ACTIVE_LOW ? ~w_font : w_font);
    w_onehot = NUM_DIGITS'(1) << idx_q;
    dig_d    = (grd_q != '0) ? C_DIG_OFF : (DIG_ACTIVE_LOW ? ~w_onehot : w_onehot);
  end

  always_ff @(posedge FPGA_clk) begin
    if (!FPGA_reset) begin
      buf_q  <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      div_q  <= '0;
      idx_q  <= '0;
      grd_q  <= '0;
      seg_q  <= C_SEG_OFF;
      dig_q  <= C_DIG_OFF;
    end else begin
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      grd_q  <= grd_d;
      seg_q  <= seg_d;
      dig_q  <= dig_d;
    end
  end

  assign seg_out     = seg_q;
  assign digit_en    = dig_q;
  assign digit_count = cnt_q;
  assign buffer_full = full_q;

endmodule
`default_nettype wire
